// File: rtl/rv_pkg.sv
// Shared encodings, widths and the decoded-op payload for the decode/operand stage.
package rv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned RAW  = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef struct packed {
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [RAW-1:0]  rd;
        logic            illegal;
    } dec_op_t;

endpackage

// File: rtl/regfile.sv
// Architectural register file: two bypassed combinational reads, one write port.
module regfile
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [RAW-1:0]  raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [RAW-1:0]  raddr2,
    output logic [XLEN-1:0] rdata2,
    input  logic            wen,
    input  logic [RAW-1:0]  waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wen && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // x0 reads as zero; a same-cycle writeback is forwarded ahead of the array.
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (wen && (waddr == raddr1)) rdata1 = wdata;
        if (wen && (waddr == raddr2)) rdata2 = wdata;
        if (raddr1 == '0) rdata1 = '0;
        if (raddr2 == '0) rdata2 = '0;
    end

endmodule

// File: rtl/decode_operand_stage.sv
// Decodes R-type / OP-IMM instructions, fetches operands with RAW interlock, and
// holds one decoded op in a valid/ready output register for the ALU.
module decode_operand_stage
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [RAW-1:0]  wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [RAW-1:0]  out_rd_addr,
    output logic            out_illegal
);

    logic [6:0]      opcode;
    logic [6:0]      f7;
    logic [2:0]      f3;
    logic [RAW-1:0]  rd_a;
    logic [RAW-1:0]  rs1_a;
    logic [RAW-1:0]  rs2_a;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;

    dec_op_t         dec;
    dec_op_t         held;
    logic            held_valid;
    logic            legal;
    logic [6:0]      f7_out;
    logic [XLEN-1:0] op_b;
    logic            use_rs1;
    logic            use_rs2;
    logic            busy1;
    logic            busy2;
    logic            accept;
    logic            fire;
    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_next;

    assign opcode = in_instr[6:0];
    assign rd_a   = in_instr[11:7];
    assign f3     = in_instr[14:12];
    assign rs1_a  = in_instr[19:15];
    assign rs2_a  = in_instr[24:20];
    assign f7     = in_instr[31:25];

    regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1_a),
        .rdata1 (rdata1),
        .raddr2 (rs2_a),
        .rdata2 (rdata2),
        .wen    (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data)
    );

    // Decode; illegal encodings carry no fields and consume no sources.
    always_comb begin
        legal   = 1'b0;
        f7_out  = F7_BASE;
        op_b    = rdata2;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        dec     = '0;
        case (opcode)
            OPC_OP: begin
                legal   = (f7 == F7_BASE) || (f7 == F7_MULDIV) ||
                          ((f7 == F7_ALT) && ((f3 == 3'd0) || (f3 == 3'd5)));
                f7_out  = f7;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                use_rs1 = 1'b1;
                case (f3)
                    3'd1: begin
                        legal = (f7 == F7_BASE);
                        op_b  = XLEN'(rs2_a);
                    end
                    3'd5: begin
                        legal  = (f7 == F7_BASE) || (f7 == F7_ALT);
                        f7_out = f7;
                        op_b   = XLEN'(rs2_a);
                    end
                    default: begin
                        legal = 1'b1;
                        op_b  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
                    end
                endcase
            end
            default: legal = 1'b0;
        endcase
        if (legal) begin
            dec.funct3 = f3;
            dec.funct7 = f7_out;
            dec.rs1    = rdata1;
            dec.rs2    = op_b;
            dec.rd     = rd_a;
        end else begin
            dec.illegal = 1'b1;
            use_rs1     = 1'b0;
            use_rs2     = 1'b0;
        end
    end

    // A writeback landing this cycle releases its pending bit via the bypass.
    assign busy1 = use_rs1 && (rs1_a != '0) &&
                   ((sb[rs1_a] && !(wb_en && (wb_addr == rs1_a))) ||
                    (held_valid && (held.rd == rs1_a)));
    assign busy2 = use_rs2 && (rs2_a != '0) &&
                   ((sb[rs2_a] && !(wb_en && (wb_addr == rs2_a))) ||
                    (held_valid && (held.rd == rs2_a)));

    assign in_ready = (!held_valid || out_ready) && !busy1 && !busy2 && !flush;
    assign accept   = in_valid && in_ready;
    assign fire     = held_valid && out_ready && !flush && !held.illegal && (held.rd != '0);

    always_comb begin
        sb_next = sb;
        if (wb_en) sb_next[wb_addr] = 1'b0;
        if (fire)  sb_next[held.rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_valid <= 1'b0;
            held       <= '0;
            sb         <= '0;
        end else begin
            sb <= sb_next;
            if (flush) begin
                held_valid <= 1'b0;
            end else if (accept) begin
                held_valid <= 1'b1;
                held       <= dec;
            end else if (out_ready) begin
                held_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = held_valid;
    assign out_funct3  = held.funct3;
    assign out_funct7  = held.funct7;
    assign out_rs1     = held.rs1;
    assign out_rs2     = held.rs2;
    assign out_rd_addr = held.rd;
    assign out_illegal = held.illegal;

endmodule

// File: tb/tb_decode_operand_stage.sv
// Randomized + directed bench for decode_operand_stage against a behavioural model.
module tb_decode_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_rs1;
    logic [31:0] out_rs2;
    logic [4:0]  out_rd_addr;
    logic        out_illegal;

    always #5 clk = ~clk;

    decode_operand_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .flush       (flush),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd_addr (out_rd_addr),
        .out_illegal (out_illegal)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_rf [32];
    logic        m_sb [32];
    logic        m_ov;
    logic        m_ill;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic [31:0] m_rs1;
    logic [31:0] m_rs2;
    logic [4:0]  m_rd;
    bit          m_init = 1'b0;
    logic        seen_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void mdecode(input logic [31:0] i, output logic ill, output logic [2:0] f3,
                                    output logic [6:0] f7, output logic [4:0] rd, output logic u1,
                                    output logic u2, output logic use_imm, output logic [31:0] imm);
        logic [6:0] hi;
        logic [2:0] fn;
        logic       ok;
        hi = i[31:25];
        fn = i[14:12];
        ok = 1'b0;
        f3 = 3'd0; f7 = 7'd0; rd = 5'd0; u1 = 1'b0; u2 = 1'b0; use_imm = 1'b0; imm = 32'd0;
        if (i[6:0] == 7'h33) begin
            ok = (hi == 7'h00) || (hi == 7'h01) || (hi == 7'h20 && (fn == 3'd0 || fn == 3'd5));
            f7 = hi; u1 = 1'b1; u2 = 1'b1;
        end else if (i[6:0] == 7'h13) begin
            use_imm = 1'b1; u1 = 1'b1;
            if (fn == 3'd1) begin
                ok = (hi == 7'h00); imm = 32'(i[24:20]);
            end else if (fn == 3'd5) begin
                ok = (hi == 7'h00) || (hi == 7'h20); f7 = hi; imm = 32'(i[24:20]);
            end else begin
                ok = 1'b1; imm = 32'(int'($signed(i[31:20])));
            end
        end
        ill = !ok;
        if (ok) begin
            f3 = fn; rd = i[11:7];
        end else begin
            f7 = 7'd0; u1 = 1'b0; u2 = 1'b0;
        end
    endfunction

    function automatic logic busy(input logic [4:0] s, input logic we, input logic [4:0] wa);
        if (s == 5'd0) return 1'b0;
        return (m_sb[s] && !(we && wa == s)) || (m_ov && m_rd == s);
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] a, input logic we, input logic [4:0] wa,
                                          input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return m_rf[a];
    endfunction

    // One clock: drive at negedge, check in_ready pre-edge, advance model, check outputs.
    task automatic cyc(input logic r, input logic iv, input logic [31:0] ins, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic ordy);
        logic ill, u1, u2, ui, haz, rdy, accept, fire;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [31:0] imm, a, b;
        rst = r; in_valid = iv; in_instr = ins; flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
        #1;
        mdecode(ins, ill, f3, f7, rd, u1, u2, ui, imm);
        haz = (u1 && busy(ins[19:15], we, wa)) || (u2 && busy(ins[24:20], we, wa));
        rdy = (!m_ov || ordy) && !haz && !fl;
        seen_ready = in_ready;
        if (m_init) chk("in_ready", 32'(in_ready), 32'(rdy));
        if (r) begin
            for (int k = 0; k < 32; k++) begin
                m_rf[k] = 32'd0; m_sb[k] = 1'b0;
            end
            m_ov = 1'b0; m_ill = 1'b0; m_f3 = 3'd0; m_f7 = 7'd0;
            m_rs1 = 32'd0; m_rs2 = 32'd0; m_rd = 5'd0; m_init = 1'b1;
        end else begin
            accept = iv && rdy;
            fire = m_ov && ordy && !fl && !m_ill && m_rd != 5'd0;
            a = mread(ins[19:15], we, wa, wd);
            b = ui ? imm : mread(ins[24:20], we, wa, wd);
            if (we) m_sb[wa] = 1'b0;
            if (fire) m_sb[m_rd] = 1'b1;
            if (we && wa != 5'd0) m_rf[wa] = wd;
            if (fl) m_ov = 1'b0;
            else if (accept) begin
                m_ov = 1'b1; m_ill = ill; m_f3 = f3; m_f7 = f7; m_rd = rd; m_rs1 = a; m_rs2 = b;
            end else if (ordy) m_ov = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_illegal", 32'(out_illegal), 32'(m_ill));
            chk("out_rd_addr", 32'(out_rd_addr), 32'(m_rd));
            chk("out_funct3", 32'(out_funct3), 32'(m_f3));
            chk("out_funct7", 32'(out_funct7), 32'(m_f7));
            if (!m_ill) begin
                chk("out_rs1", out_rs1, m_rs1);
                chk("out_rs2", out_rs2, m_rs2);
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  hi;
        logic [2:0]  fn;
        logic [4:0]  rd, r1, r2;
        logic [6:0]  f7tab [6];
        int          sel;
        f7tab = '{7'h00, 7'h01, 7'h20, 7'h20, 7'h21, 7'h00};
        f7tab[5] = 7'($urandom);
        rd = 5'($urandom_range(0, 7));
        r1 = 5'($urandom_range(0, 7));
        r2 = 5'($urandom_range(0, 7));
        fn = 3'($urandom);
        sel = int'($urandom_range(0, 9));
        if (sel <= 3) begin
            hi = f7tab[$urandom_range(0, 5)];
            return {hi, r2, r1, fn, rd, 7'h33};
        end else if (sel <= 7) begin
            hi = ($urandom_range(0, 2) == 0) ? 7'h20 : (($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00);
            if ($urandom_range(0, 1) == 1) fn = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5;
            return {hi, r2, r1, fn, rd, 7'h13};
        end else if (sel == 8) begin
            return {hi, r2, r1, fn, rd, 7'($urandom)};
        end
        return $urandom;
    endfunction

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_ADDI  = 32'hFFF00293;
    localparam logic [31:0] I_SRAI  = 32'h4042D313;
    localparam logic [31:0] I_MUL   = 32'h022083B3;
    localparam logic [31:0] I_ADD8  = 32'h00038433;
    localparam logic [31:0] I_ADD9  = 32'h002084B3;
    localparam logic [31:0] I_ADDI10 = 32'h00148513;
    localparam logic [31:0] I_ADD4  = 32'h00518233;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b0;
        @(negedge clk);

        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_illegal", 32'(out_illegal), 0);
        chk("rst_rs1", out_rs1, 0);
        chk("rst_rd", 32'(out_rd_addr), 0);

        cyc(0, 0, 0, 0, 1, 1, 5, 1);
        cyc(0, 0, 0, 0, 1, 2, 7, 1);

        cyc(0, 1, I_ADD, 0, 0, 0, 0, 1);
        chk("add_ready", 32'(seen_ready), 1);
        chk("add_valid", 32'(out_valid), 1);
        chk("add_f7", 32'(out_funct7), 0);
        chk("add_rs1", out_rs1, 5);
        chk("add_rs2", out_rs2, 7);
        chk("add_rd", 32'(out_rd_addr), 3);

        cyc(0, 1, I_ADDI, 0, 0, 0, 0, 1);
        chk("addi_rs1", out_rs1, 0);
        chk("addi_rs2", out_rs2, 32'hFFFF_FFFF);
        chk("addi_rd", 32'(out_rd_addr), 5);

        cyc(0, 1, I_SRAI, 0, 0, 0, 0, 1);
        chk("srai_stall0", 32'(seen_ready), 0);
        cyc(0, 1, I_SRAI, 0, 0, 0, 0, 1);
        chk("srai_stall1", 32'(seen_ready), 0);
        cyc(0, 1, I_SRAI, 0, 1, 5, 32'h8000_0000, 1);
        chk("srai_bypass_ready", 32'(seen_ready), 1);
        chk("srai_rs1", out_rs1, 32'h8000_0000);
        chk("srai_rs2", out_rs2, 4);
        chk("srai_f3", 32'(out_funct3), 5);
        chk("srai_f7", 32'(out_funct7), 32'h20);

        cyc(0, 1, I_MUL, 0, 0, 0, 0, 1);
        chk("mul_rd", 32'(out_rd_addr), 7);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, I_ADD8, 0, 0, 0, 0, 0);
            chk("mul_hold_ready", 32'(seen_ready), 0);
            chk("mul_hold_f7", 32'(out_funct7), 1);
            chk("mul_hold_rs2", out_rs2, 7);
        end
        cyc(0, 1, I_ADD8, 0, 0, 0, 0, 1);
        chk("x7_stall_a", 32'(seen_ready), 0);
        cyc(0, 1, I_ADD8, 0, 0, 0, 0, 1);
        chk("x7_stall_b", 32'(seen_ready), 0);
        cyc(0, 1, I_ADD8, 0, 1, 7, 42, 1);
        chk("x7_release", out_rs1, 42);

        cyc(0, 1, 32'h0000_0000, 0, 0, 0, 0, 1);
        chk("zero_illegal", 32'(out_illegal), 1);
        chk("zero_rd", 32'(out_rd_addr), 0);
        cyc(0, 1, 32'h4200_9133, 0, 0, 0, 0, 1);
        chk("f7_21_illegal", 32'(out_illegal), 1);

        cyc(0, 1, I_ADD9, 0, 0, 0, 0, 1);
        cyc(0, 1, I_ADDI, 1, 0, 0, 0, 1);
        chk("flush_ready", 32'(seen_ready), 0);
        chk("flush_valid", 32'(out_valid), 0);
        cyc(0, 1, I_ADDI10, 0, 0, 0, 0, 1);
        chk("flush_no_sb", 32'(seen_ready), 1);

        cyc(0, 1, I_MUL, 0, 0, 0, 0, 1);
        cyc(0, 1, I_ADD8, 0, 0, 0, 0, 0);
        cyc(1, 1, I_ADD8, 0, 0, 0, 0, 0);
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_rs1", out_rs1, 0);
        chk("midrst_f7", 32'(out_funct7), 0);
        cyc(0, 1, I_ADD4, 0, 0, 0, 0, 1);
        chk("midrst_sb_clear", 32'(seen_ready), 1);
        chk("midrst_regs_zero", out_rs1, 0);

        for (int n = 0; n < 4000; n++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), rand_instr(),
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 4),
                5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 9) < 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_operand_stage.md
Name: decode_operand_stage

Overview:
Decode and operand-fetch stage sitting directly upstream of the RV32I/RV32M ALU. It accepts one 32-bit instruction per handshake and decodes the R-type (0110011) and OP-IMM (0010011) formats. It reads the 32-entry register file, with bypass from writeback and a pending-write scoreboard for RAW interlock. It presents funct3/funct7/rs1/rs2 operand values plus the destination register to the ALU through a registered valid/ready output.

Parameters:
XLEN, 32, datapath and register width
NREG, 32, number of architectural registers; x0 is hardwired to zero

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  instruction present
in_ready  out  1  stage accepts instruction this cycle
in_instr  in  32  raw instruction word
flush  in  1  kill the held output and any same-cycle accept
wb_en  in  1  writeback strobe
wb_addr  in  5  writeback register index
wb_data  in  XLEN  writeback value
out_valid  out  1  decoded op valid to ALU
out_ready  in  1  ALU consumes op
out_funct3  out  3  ALU funct3
out_funct7  out  7  ALU funct7 (0x00/0x20/0x01)
out_rs1  out  XLEN  operand A value
out_rs2  out  XLEN  operand B value (register or sign-extended immediate)
out_rd_addr  out  5  destination index; 0 when illegal
out_illegal  out  1  unsupported or malformed encoding

Behaviour:
- Reset: out_valid=0, out_illegal=0, all out_* data=0, scoreboard=0, all registers=0. A reset asserted mid-operation drops any held op.
- Latency: 1 cycle from accept (in_valid && in_ready) to out_valid.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Output register holds its value stably while out_valid && !out_ready.
- Decode:
  - R-type: funct7 must be 0x00, 0x01, or 0x20.
  - funct7 0x20 is legal only with funct3 0 or 5.
  - op_b = reg[rs2].
- OP-IMM:
  - op_b = sign-extend(instr[31:20]).
  - out_funct7 = 0x00, except shifts.
  - SLLI requires instr[31:25]=0x00.
  - SRLI/SRAI requires instr[31:25] to be 0x00 or 0x20; out_funct7 takes that value.
  - op_b = zero-extend(instr[24:20]).
- Any other opcode or violation is illegal:
  - out_illegal=1; out_funct3, out_funct7 and out_rd_addr are 0; operands are don't-care.
  - Illegal ops still handshake out.
- Regfile:
  - Write on clk when wb_en && wb_addr!=0.
  - Reads of x0 return 0.
  - Same-cycle read of wb_addr (nonzero) returns wb_data (bypass).
- Scoreboard (NREG bits):
  - Set bit rd when out_valid && out_ready && rd!=0 && !illegal.
  - Clear bit wb_addr on wb_en.
  - Same-cycle set and clear of the same index: the set wins.
- Hazard: a used source s (s!=0) is hazardous if either:
  - scoreboard[s] is set and not (wb_en && wb_addr==s); or
  - out_valid and out_rd_addr==s, regardless of out_ready that cycle.
- Only decoded-as-used sources count; OP-IMM ignores rs2.
- flush:
  - next cycle out_valid=0;
  - no accept occurs that cycle;
  - the scoreboard is unchanged, since the held op never set a bit.
- Simultaneous flush and out_ready: the handshake is suppressed; the op does not set the scoreboard.

Decomposition:
- Package rv_pkg:
  - OPC_OP=7'b0110011, OPC_OP_IMM=7'b0010011;
  - F7_BASE=0x00, F7_ALT=0x20, F7_MULDIV=0x01;
  - a typedef struct for the decoded op (funct3, funct7, rs1, rs2, rd, illegal).
- One sub-module, regfile: 2 combinational read ports with writeback bypass, 1 write port, synchronous reset.

Test Plan:
- x1=5, x2=7 via wb; issue 0x002081B3 (ADD x3,x1,x2) -> next cycle out_valid=1, funct3=0, funct7=0x00, rs1=5, rs2=7, rd=3.
- Issue 0xFFF00293 (ADDI x5,x0,-1) -> out_rs1=0, out_rs2=0xFFFFFFFF, funct7=0x00, rd=5.
- Issue 0x4042D313 (SRAI x6,x5,4) with x5 pending:
  - in_ready=0 until wb_en, wb_addr=5;
  - in that wb cycle the op is accepted with rs1=wb_data (bypass);
  - result: rs2=4, funct3=5, funct7=0x20.
- Issue 0x022083B3 (MUL x7,x1,x2) with out_ready=0 for 3 cycles -> outputs stable, in_ready=0; next op reading x7 stalls until x7 is written back.
- Issue 0x00000000 -> out_illegal=1, rd=0, scoreboard unchanged; issue 0x42009133 (funct7 0x21) -> illegal.
- Assert flush while out_valid=1 and in_valid=1 -> next cycle out_valid=0, instruction not accepted; assert rst mid-stall -> all outputs and scoreboard zero.
